// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec: single-issue RV32I integer/jump/branch execution unit.
//
// Accepts one instruction per cycle from the reservation station's ALU
// dispatch port and broadcasts the tagged result one cycle later on the ALU
// result bus.
//
// Ports
//   clk                 system clock, all state on the rising edge
//   rst_n               synchronous active-low reset, clears every output
//   rdy                 global ready; low freezes all state and outputs
//   rollback            misprediction flush; kills the broadcast and the
//                       instruction presented in the same cycle
//   alu_en              dispatch valid (one-cycle pulse per instruction)
//   alu_opcode          instruction bits [6:0]
//   alu_funct3          instruction bits [14:12]
//   alu_funct7          instruction bit 30 (sub/sra select)
//   alu_val1/alu_val2   rs1/rs2 operand values
//   alu_imm             decoded immediate
//   alu_pc              instruction PC
//   alu_rob_pos         destination ROB entry
//   alu_result          result valid pulse
//   alu_result_rob_pos  ROB tag of the broadcast result
//   alu_result_val      rd write value
//   alu_result_jump     control transfer taken
//   alu_result_pc       resolved next PC
// ---------------------------------------------------------------------------
module alu_exec #(
    parameter int ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 alu_en,
    input  logic [6:0]           alu_opcode,
    input  logic [2:0]           alu_funct3,
    input  logic                 alu_funct7,
    input  logic [31:0]          alu_val1,
    input  logic [31:0]          alu_val2,
    input  logic [31:0]          alu_imm,
    input  logic [31:0]          alu_pc,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    output logic                 alu_result,
    output logic [ROB_POS_W-1:0] alu_result_rob_pos,
    output logic [31:0]          alu_result_val,
    output logic                 alu_result_jump,
    output logic [31:0]          alu_result_pc
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic                 is_op_s;
    logic [31:0]          op_b_s;
    logic [4:0]           shamt_s;
    logic [31:0]          pc_plus4_s;
    logic [31:0]          pc_plus_imm_s;
    logic [31:0]          alu_val_s;
    logic                 br_cond_s;
    logic [31:0]          res_val_s;
    logic                 res_jump_s;
    logic [31:0]          res_pc_s;

    logic                 valid_d, valid_q;
    logic [ROB_POS_W-1:0] rob_pos_d, rob_pos_q;
    logic [31:0]          val_d, val_q;
    logic                 jump_d, jump_q;
    logic [31:0]          pc_d, pc_q;

    assign is_op_s       = (alu_opcode == OPC_OP);
    assign op_b_s        = is_op_s ? alu_val2 : alu_imm;
    assign shamt_s       = op_b_s[4:0];
    assign pc_plus4_s    = alu_pc + 32'd4;
    assign pc_plus_imm_s = alu_pc + alu_imm;

    // Integer ALU for OP and OP-IMM.
    always_comb begin
        alu_val_s = 32'd0;
        case (alu_funct3)
            3'b000: begin
                // ADDI never subtracts: imm bit 30 is just part of the immediate.
                if (is_op_s && alu_funct7) begin
                    alu_val_s = alu_val1 - op_b_s;
                end else begin
                    alu_val_s = alu_val1 + op_b_s;
                end
            end
            3'b001: alu_val_s = alu_val1 << shamt_s;
            3'b010: alu_val_s = ($signed(alu_val1) < $signed(op_b_s)) ? 32'd1 : 32'd0;
            3'b011: alu_val_s = (alu_val1 < op_b_s) ? 32'd1 : 32'd0;
            3'b100: alu_val_s = alu_val1 ^ op_b_s;
            3'b101: begin
                if (alu_funct7) begin
                    alu_val_s = $unsigned($signed(alu_val1) >>> shamt_s);
                end else begin
                    alu_val_s = alu_val1 >> shamt_s;
                end
            end
            3'b110: alu_val_s = alu_val1 | op_b_s;
            3'b111: alu_val_s = alu_val1 & op_b_s;
            default: alu_val_s = 32'd0;
        endcase
    end

    // Branch condition; the two illegal funct3 encodings never take.
    always_comb begin
        br_cond_s = 1'b0;
        case (alu_funct3)
            3'b000: br_cond_s = (alu_val1 == alu_val2);
            3'b001: br_cond_s = (alu_val1 != alu_val2);
            3'b100: br_cond_s = ($signed(alu_val1) <  $signed(alu_val2));
            3'b101: br_cond_s = ($signed(alu_val1) >= $signed(alu_val2));
            3'b110: br_cond_s = (alu_val1 <  alu_val2);
            3'b111: br_cond_s = (alu_val1 >= alu_val2);
            default: br_cond_s = 1'b0;
        endcase
    end

    // Opcode-level result selection (value, jump flag, next PC).
    always_comb begin
        res_val_s  = 32'd0;
        res_jump_s = 1'b0;
        res_pc_s   = pc_plus4_s;
        case (alu_opcode)
            OPC_OP, OPC_OP_IMM: res_val_s = alu_val_s;
            OPC_LUI:            res_val_s = alu_imm;
            OPC_AUIPC:          res_val_s = pc_plus_imm_s;
            OPC_JAL: begin
                res_val_s  = pc_plus4_s;
                res_jump_s = 1'b1;
                res_pc_s   = pc_plus_imm_s;
            end
            OPC_JALR: begin
                res_val_s  = pc_plus4_s;
                res_jump_s = 1'b1;
                res_pc_s   = (alu_val1 + alu_imm) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                res_jump_s = br_cond_s;
                if (br_cond_s) begin
                    res_pc_s = pc_plus_imm_s;
                end else begin
                    res_pc_s = pc_plus4_s;
                end
            end
            // Unknown opcodes still broadcast so the ROB entry can retire.
            default: begin
                res_val_s  = 32'd0;
                res_jump_s = 1'b0;
                res_pc_s   = pc_plus4_s;
            end
        endcase
    end

    // Next-state for the result register: rollback beats rdy; data holds when idle.
    always_comb begin
        valid_d   = valid_q;
        rob_pos_d = rob_pos_q;
        val_d     = val_q;
        jump_d    = jump_q;
        pc_d      = pc_q;
        if (rollback) begin
            valid_d = 1'b0;
        end else if (rdy) begin
            valid_d = alu_en;
            if (alu_en) begin
                rob_pos_d = alu_rob_pos;
                val_d     = res_val_s;
                jump_d    = res_jump_s;
                pc_d      = res_pc_s;
            end else begin
                rob_pos_d = rob_pos_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Result register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rob_pos_q <= '0;
            val_q     <= 32'd0;
            jump_q    <= 1'b0;
            pc_q      <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            rob_pos_q <= rob_pos_d;
            val_q     <= val_d;
            jump_q    <= jump_d;
            pc_q      <= pc_d;
        end
    end

    assign alu_result         = valid_q;
    assign alu_result_rob_pos = rob_pos_q;
    assign alu_result_val     = val_q;
    assign alu_result_jump    = jump_q;
    assign alu_result_pc      = pc_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

    typedef struct packed {
        logic [3:0]  pos;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rollback;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;
    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        alu_result_jump;
    logic [31:0] alu_result_pc;

    res_t q[$];
    res_t last_exp;
    logic exp_valid;
    int   n_pass;
    int   n_total;

    alu_exec #(.ROB_POS_W(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rdy                (rdy),
        .rollback           (rollback),
        .alu_en             (alu_en),
        .alu_opcode         (alu_opcode),
        .alu_funct3         (alu_funct3),
        .alu_funct7         (alu_funct7),
        .alu_val1           (alu_val1),
        .alu_val2           (alu_val2),
        .alu_imm            (alu_imm),
        .alu_pc             (alu_pc),
        .alu_rob_pos        (alu_rob_pos),
        .alu_result         (alu_result),
        .alu_result_rob_pos (alu_result_rob_pos),
        .alu_result_val     (alu_result_val),
        .alu_result_jump    (alu_result_jump),
        .alu_result_pc      (alu_result_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one instruction; the expected result is pushed only when the bench
    // knows the edge will accept it.
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [3:0] pos);
        alu_en      = 1'b1;
        alu_opcode  = op;
        alu_funct3  = f3;
        alu_funct7  = f7;
        alu_val1    = v1;
        alu_val2    = v2;
        alu_imm     = imm;
        alu_pc      = pc;
        alu_rob_pos = pos;
    endtask

    task automatic expect_res(input logic [3:0] pos, input logic [31:0] val,
                              input logic jump, input logic [31:0] pc);
        res_t r;
        r.pos  = pos;
        r.val  = val;
        r.jump = jump;
        r.pc   = pc;
        q.push_back(r);
    endtask

    // One clock: update the reference model from the inputs seen at the edge,
    // then compare every output 1 time unit after the edge.
    task automatic tick(input string tag);
        logic s_rst_n, s_rb, s_rdy, s_en;
        s_rst_n = rst_n;
        s_rb    = rollback;
        s_rdy   = rdy;
        s_en    = alu_en;
        @(posedge clk);
        #1;
        if (!s_rst_n) begin
            exp_valid = 1'b0;
            last_exp  = '0;
        end else if (s_rb) begin
            exp_valid = 1'b0;
        end else if (s_rdy) begin
            exp_valid = s_en;
            if (s_en) begin
                n_total++;
                assert (q.size() > 0) n_pass++;
                else $error("FAIL %s scoreboard_underflow observed=0 expected=1", tag);
                if (q.size() > 0) begin
                    last_exp = q.pop_front();
                end else begin
                    last_exp = last_exp;
                end
            end else begin
                exp_valid = 1'b0;
            end
        end else begin
            exp_valid = exp_valid;
        end
        check({tag, ".valid"}, {31'd0, alu_result}, {31'd0, exp_valid});
        check({tag, ".pos"},   {28'd0, alu_result_rob_pos}, {28'd0, last_exp.pos});
        check({tag, ".val"},   alu_result_val, last_exp.val);
        check({tag, ".jump"},  {31'd0, alu_result_jump}, {31'd0, last_exp.jump});
        check({tag, ".pc"},    alu_result_pc, last_exp.pc);
    endtask

    initial begin
        clk       = 1'b0;
        n_pass    = 0;
        n_total   = 0;
        exp_valid = 1'b0;
        last_exp  = '0;
        rst_n     = 1'b0;
        rdy       = 1'b1;
        rollback  = 1'b0;

        // Reset held two cycles with a dispatch present: nothing may emerge.
        drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'h0, 4'd9);
        tick("reset0");
        tick("reset1");
        rst_n = 1'b1;

        // SUB 5-7
        drive(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'h0, 4'd1);
        expect_res(4'd1, 32'hFFFF_FFFE, 1'b0, 32'h4);
        tick("sub");
        // SRAI by 4 (imm 0x404: upper shift bits ignored)
        drive(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h404, 32'h10, 4'd2);
        expect_res(4'd2, 32'hF800_0000, 1'b0, 32'h14);
        tick("srai");
        // ADDI with imm bit 30 set must add
        drive(7'b0010011, 3'b000, 1'b1, 32'h1000, 32'd0, 32'hFFFF_F800, 32'h20, 4'd3);
        expect_res(4'd3, 32'h800, 1'b0, 32'h24);
        tick("addi");
        // BLT signed: -1 < 1 taken
        drive(7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd4);
        expect_res(4'd4, 32'd0, 1'b1, 32'h120);
        tick("blt");
        // BLTU: 0xFFFFFFFF < 1 not taken
        drive(7'b1100011, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd5);
        expect_res(4'd5, 32'd0, 1'b0, 32'h104);
        tick("bltu");
        // JALR clears bit 0 of the target
        drive(7'b1100111, 3'b000, 1'b0, 32'h1003, 32'd0, 32'h10, 32'h200, 4'd6);
        expect_res(4'd6, 32'h204, 1'b1, 32'h1012);
        tick("jalr");
        // JAL at top of address space: pc+4 and pc+imm wrap
        drive(7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h8, 32'hFFFF_FFFC, 4'd9);
        expect_res(4'd9, 32'h0, 1'b1, 32'h4);
        tick("jal_wrap");
        // Unknown opcode still broadcasts
        drive(7'b0000000, 3'b000, 1'b0, 32'd3, 32'd4, 32'd5, 32'h600, 4'd10);
        expect_res(4'd10, 32'd0, 1'b0, 32'h604);
        tick("unknown");
        alu_en = 1'b0;
        tick("idle0");

        // Three back-to-back ADDs
        drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'h300, 4'd1);
        expect_res(4'd1, 32'd3, 1'b0, 32'h304);
        tick("pipe1");
        drive(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 32'h304, 4'd2);
        expect_res(4'd2, 32'd7, 1'b0, 32'h308);
        tick("pipe2");
        drive(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd6, 32'd0, 32'h308, 4'd3);
        expect_res(4'd3, 32'd11, 1'b0, 32'h30C);
        tick("pipe3");
        alu_en = 1'b0;
        tick("pipe_idle");

        // Same, with rollback on the third dispatch
        drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'h300, 4'd1);
        expect_res(4'd1, 32'd3, 1'b0, 32'h304);
        tick("rb1");
        drive(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 32'h304, 4'd2);
        expect_res(4'd2, 32'd7, 1'b0, 32'h308);
        tick("rb2");
        drive(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd6, 32'd0, 32'h308, 4'd3);
        rollback = 1'b1;
        tick("rb3");
        rollback = 1'b0;
        alu_en   = 1'b0;
        tick("rb_idle0");
        tick("rb_idle1");
        check("sb_empty_rb", q.size(), 32'd0);

        // rdy stall holds the LUI pulse; a dispatch during stall is ignored
        drive(7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h400, 4'd7);
        expect_res(4'd7, 32'h1234_5000, 1'b0, 32'h404);
        tick("lui");
        rdy = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 32'h700, 4'd12);
        tick("stall0");
        tick("stall1");
        alu_en = 1'b0;
        tick("stall2");
        rdy = 1'b1;
        tick("unstall");

        // Rollback overrides a stall and kills the displayed pulse
        drive(7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h500, 4'd8);
        expect_res(4'd8, 32'h1500, 1'b0, 32'h504);
        tick("auipc");
        alu_en   = 1'b0;
        rdy      = 1'b0;
        rollback = 1'b1;
        tick("rb_stall");
        rdy      = 1'b1;
        rollback = 1'b0;
        tick("rb_stall_idle");

        // Reset mid-operation clears a displayed result
        drive(7'b0110011, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h800, 4'd11);
        expect_res(4'd11, 32'hF000_F000, 1'b0, 32'h804);
        tick("and");
        rst_n = 1'b0;
        tick("reset_mid");
        rst_n  = 1'b1;
        alu_en = 1'b0;
        tick("post_reset");
        check("sb_empty_end", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
